// File: rtl/boot_seq_ctrl_pkg.sv
// Shared types and constants for the boot sequencer.
// Holds the FSM state encoding, the per-target register map offsets and
// a helper that sizes target index signals.
package boot_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_WR_MODE,
    S_WR_ENTRY,
    S_WR_FETCH,
    S_WAIT,
    S_RD_REQ,
    S_RD_RSP,
    S_FIN
  } state_e;

  // Per-target control block layout (byte offsets from the block base)
  localparam logic [31:0] BOOTMODE_OFF = 32'h0;
  localparam logic [31:0] ENTRY_OFF    = 32'h4;
  localparam logic [31:0] FETCH_EN_OFF = 32'h8;
  localparam logic [31:0] STATUS_OFF   = 32'hC;

  // STATUS: bit31 = end of computation, [30:0] = exit status
  localparam int STATUS_EOC_BIT = 31;

  // Width of a target index; never below one bit so single-target builds work.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boot_seq_prio_sel.sv
// Lowest-set-bit selector over (mask & ~done), considering only positions
// at or above start_i. Used both to walk targets during boot and to pick
// the next pending target while polling.
module boot_seq_prio_sel
  import boot_seq_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [N-1:0]  done_i,
  input  logic [IW:0]   start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  localparam int SW = IW + 1;

  logic [N-1:0] cand;
  assign cand = mask_i & ~done_i;

  // Scan upward from start_i and keep the first candidate hit
  always_comb begin
    logic hit;
    hit   = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && cand[i] && (SW'(i) >= start_i)) begin
        hit   = 1'b1;
        idx_o = IW'(i);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: bus master that boots each enabled target
// (BOOTMODE, ENTRY, FETCH_EN writes) and then polls every target's STATUS
// register until all report end of computation.
// Optional watchdog: define BOOT_SEQ_CTRL_TIMEOUT_EN to abort the sequence
// with error_o after TimeoutCycles cycles.
module boot_seq_ctrl
  import boot_seq_ctrl_pkg::*;
#(
  parameter int                   NumTargets    = 4,
  parameter int                   AddrWidth     = 32,
  parameter int                   DataWidth     = 32,
  parameter logic [AddrWidth-1:0] BaseAddr      = 32'h1A10_4000,
  parameter logic [AddrWidth-1:0] TargetStride  = 32'h100,
  parameter int                   PollInterval  = 256,
  parameter int                   TimeoutCycles = 2**20
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [DataWidth-1:0]                  bootmode_i,
  input  logic [NumTargets-1:0][DataWidth-1:0]  entry_point_i,
  input  logic [NumTargets-1:0]                 target_en_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  error_o,
  output logic [NumTargets-1:0]                 eoc_o,
  output logic [NumTargets-1:0][30:0]           exit_status_o,
  output logic                                  req_o,
  output logic                                  we_o,
  output logic [AddrWidth-1:0]                  addr_o,
  output logic [DataWidth-1:0]                  wdata_o,
  input  logic                                  gnt_i,
  input  logic                                  rvalid_i,
  input  logic [DataWidth-1:0]                  rdata_i
);

  localparam int IW = idx_w(NumTargets);
  localparam int SW = IW + 1;
  localparam int PW = $clog2(PollInterval + 1);

  state_e                       state_q;
  logic [NumTargets-1:0]        mask_q;
  logic [NumTargets-1:0]        eoc_q;
  logic [NumTargets-1:0][30:0]  exit_q;
  logic [IW-1:0]                idx_q;
  logic [PW-1:0]                poll_q;
  logic                         req_q, we_q, done_q;
  logic [AddrWidth-1:0]         addr_q;
  logic [DataWidth-1:0]         wdata_q;
  logic                         aborting;

  // Shared selector: boot walk, poll-round start and poll-round advance
  logic [NumTargets-1:0] sel_mask, sel_done;
  logic [SW-1:0]         sel_start;
  logic                  sel_found;
  logic [IW-1:0]         sel_idx;

  // Pick selector operands by phase; LATCH/WAIT search from target 0
  always_comb begin
    sel_mask  = (state_q == S_LATCH) ? target_en_i : mask_q;
    sel_done  = (state_q == S_LATCH) ? '0 : eoc_q;
    sel_start = (state_q == S_LATCH || state_q == S_WAIT) ? '0
                                                          : SW'(idx_q) + SW'(1);
  end

  boot_seq_prio_sel #(.N(NumTargets), .IW(IW)) u_sel (
    .mask_i  (sel_mask),
    .done_i  (sel_done),
    .start_i (sel_start),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  // Address/data of the access the current state issues
  logic [AddrWidth-1:0] tgt_base, bus_off;
  logic [DataWidth-1:0] bus_wdata;
  logic                 bus_we;

  assign tgt_base = BaseAddr + AddrWidth'(idx_q) * TargetStride;

  // Decode register offset and write payload for the current bus state
  always_comb begin
    bus_off   = AddrWidth'(STATUS_OFF);
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state_q)
      S_WR_MODE:  begin bus_off = AddrWidth'(BOOTMODE_OFF); bus_wdata = bootmode_i;           bus_we = 1'b1; end
      S_WR_ENTRY: begin bus_off = AddrWidth'(ENTRY_OFF);    bus_wdata = entry_point_i[idx_q]; bus_we = 1'b1; end
      S_WR_FETCH: begin bus_off = AddrWidth'(FETCH_EN_OFF); bus_wdata = DataWidth'(1);        bus_we = 1'b1; end
      default:    ;
    endcase
  end

  // End-of-round check includes the response being consumed this cycle
  logic [NumTargets-1:0] hit_vec;
  logic                  all_done;
  assign hit_vec  = rdata_i[STATUS_EOC_BIT] ? (NumTargets'(1) << idx_q) : '0;
  assign all_done = ((eoc_q | hit_vec) & mask_q) == mask_q;

`ifdef BOOT_SEQ_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TimeoutCycles + 1);
  logic [WW-1:0] wdog_q;
  logic          error_q;
  logic          wdog_hit;
  assign wdog_hit = !error_q && (wdog_q == WW'(TimeoutCycles)) &&
                    (state_q != S_IDLE) && (state_q != S_LATCH) && (state_q != S_FIN);
  assign aborting = error_q;
  assign error_o  = error_q;
`else
  localparam int unused_timeout = TimeoutCycles;
  assign aborting = 1'b0;
  assign error_o  = 1'b0;
`endif

  // Main sequencer: boot walk, poll rounds and the bus handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      eoc_q   <= '0;
      exit_q  <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
`ifdef BOOT_SEQ_CTRL_TIMEOUT_EN
      wdog_q  <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) state_q <= S_LATCH;

        S_LATCH: begin
          mask_q <= target_en_i;
          eoc_q  <= '0;
          exit_q <= '0;
`ifdef BOOT_SEQ_CTRL_TIMEOUT_EN
          error_q <= 1'b0;
`endif
          if (sel_found) begin
            idx_q   <= sel_idx;
            state_q <= S_WR_MODE;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end

        S_WR_MODE, S_WR_ENTRY, S_WR_FETCH, S_RD_REQ: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= bus_we;
            addr_q  <= tgt_base + bus_off;
            wdata_q <= bus_wdata;
          end else if (gnt_i) begin
            req_q <= 1'b0;
            case (state_q)
              S_WR_MODE:  state_q <= S_WR_ENTRY;
              S_WR_ENTRY: state_q <= S_WR_FETCH;
              S_WR_FETCH: begin
                if (sel_found) begin
                  idx_q   <= sel_idx;
                  state_q <= S_WR_MODE;
                end else begin
                  poll_q  <= '0;
                  state_q <= S_WAIT;
                end
              end
              default:    state_q <= S_RD_RSP;
            endcase
          end
        end

        S_WAIT: begin
          if (poll_q == PW'(PollInterval - 1)) begin
            poll_q <= '0;
            if (sel_found) begin
              idx_q   <= sel_idx;
              state_q <= S_RD_REQ;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end else begin
            poll_q <= poll_q + PW'(1);
          end
        end

        S_RD_RSP: begin
          if (rvalid_i) begin
            if (aborting) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              if (rdata_i[STATUS_EOC_BIT]) begin
                eoc_q[idx_q]  <= 1'b1;
                exit_q[idx_q] <= rdata_i[30:0];
              end
              if (sel_found) begin
                idx_q   <= sel_idx;
                state_q <= S_RD_REQ;
              end else if (all_done) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                poll_q  <= '0;
                state_q <= S_WAIT;
              end
            end
          end
        end

        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

`ifdef BOOT_SEQ_CTRL_TIMEOUT_EN
      if (state_q == S_LATCH)
        wdog_q <= '0;
      else if (state_q != S_IDLE && state_q != S_FIN && wdog_q != WW'(TimeoutCycles))
        wdog_q <= wdog_q + WW'(1);
      // Watchdog overrides the walk; partial results stay, an in-flight read drains
      if (wdog_hit) begin
        error_q <= 1'b1;
        req_q   <= 1'b0;
        eoc_q   <= eoc_q;
        exit_q  <= exit_q;
        if ((state_q == S_RD_RSP && !rvalid_i) ||
            (state_q == S_RD_REQ && req_q && gnt_i)) begin
          state_q <= S_RD_RSP;
          done_q  <= 1'b0;
        end else begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
      end
`endif
    end
  end

  // Upper read-data bits are don't-care when DataWidth exceeds 32
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign eoc_o         = eoc_q;
  assign exit_status_o = exit_q;
  assign req_o         = req_q;
  assign we_o          = we_q;
  assign addr_o        = addr_q;
  assign wdata_o       = wdata_q;

endmodule

// File: doc/boot_seq_ctrl.md
Name: boot_seq_ctrl

Overview:
- Synthesizable boot sequencer. Replaces the software-driven flow used for boot: select bootmode, write entry point, assert fetch enable, wait for end-of-computation.
- Generalised to NumTargets independently enabled cores/clusters.
- Acts as a register-bus master on the SoC control interconnect. Boots each target, then polls every target's EOC/status register and captures its exit status.

Parameters:
- NumTargets, 4, number of bootable targets (1..16)
- AddrWidth, 32, bus address width
- DataWidth, 32, bus data width (>=32)
- BaseAddr, 32'h1A10_4000, target 0 control block base
- TargetStride, 32'h100, address distance between consecutive target blocks
- PollInterval, 256, idle cycles between EOC polling rounds (>=1)
- TimeoutCycles, 2**20, watchdog limit (used only with macro)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  single-cycle start pulse
- bootmode_i  in  DataWidth  value written to each target's BOOTMODE register
- entry_point_i  in  NumTargets x DataWidth  per-target entry point
- target_en_i  in  NumTargets  targets to boot; sampled at start
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when the sequence ends
- error_o  out  1  sticky; set when the timeout fires; cleared by the next start
- eoc_o  out  NumTargets  per-target EOC seen (sticky until next start)
- exit_status_o  out  NumTargets x 31  captured exit status per target
- req_o, we_o  out  1  bus request and write enable
- addr_o  out  AddrWidth  bus address
- wdata_o  out  DataWidth  bus write data
- gnt_i  in  1  bus grant
- rvalid_i  in  1  read response valid
- rdata_i  in  DataWidth  read response data

Behaviour:
- Register map, per target t, at Base = BaseAddr + t*TargetStride:
  - BOOTMODE at +0x0
  - ENTRY at +0x4
  - FETCH_EN at +0x8 (write 1)
  - STATUS at +0xC: bit31 = eoc, [30:0] = exit status
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Bus handshake:
  - req_o, addr_o, we_o and wdata_o stay stable from assertion until the cycle gnt_i=1.
  - A write completes on the grant cycle.
  - A read completes on the first rvalid_i after its grant; only one read is outstanding at a time.
  - req_o deasserts the cycle after the grant.
- FSM transitions:
  - IDLE -> LATCH on start_i. start_i is ignored while busy_o=1.
  - LATCH: latch target_en_i and clear eoc_o/exit_status_o/error_o. If the mask is 0, go to FIN. Otherwise set idx to the lowest enabled target and go to WR_MODE.
  - WR_MODE -> WR_ENTRY -> WR_FETCH, each advancing on gnt_i.
  - After WR_FETCH: go to WR_MODE of the next enabled idx (ascending order); after the last one, go to WAIT.
  - WAIT: count PollInterval cycles, then start a round at the lowest enabled target with eoc_o=0 and go to RD_REQ.
  - RD_REQ -> RD_RSP on gnt.
  - RD_RSP on rvalid: if rdata[31]=1, set eoc_o[idx] and capture exit_status_o[idx] = rdata[30:0]. Then move to the next pending target, or to WAIT at the end of the round.
  - If all enabled targets have eoc_o=1, go to FIN.
  - FIN: pulse done_o for one cycle, then return to IDLE.
- busy_o is 1 in every state except IDLE.
- Non-enabled targets are never accessed, and their eoc_o stays 0.
- Address arithmetic: BaseAddr + idx*TargetStride + offset, computed modulo 2**AddrWidth (wraps).
- rst_i asserted mid-transaction: abandon immediately with no completion. req_o is 0 on the next cycle; rvalid_i arriving after reset is ignored.
- start_i in the same cycle as rst_i: reset wins.

Optional Feature:
- Macro: BOOT_SEQ_CTRL_TIMEOUT_EN
- Defined: a watchdog counter runs from LATCH to FIN and saturates at TimeoutCycles.
  - On reaching TimeoutCycles: set error_o, drop any pending request (an in-flight read is still waited for and then discarded), go to FIN.
  - Partial eoc_o/exit_status_o results are kept.
- Undefined: no counter; error_o is tied to 0; polling waits indefinitely.

Decomposition:
- Package boot_seq_ctrl_pkg:
  - FSM state enum
  - register offset constants (BOOTMODE_OFF, ENTRY_OFF, FETCH_EN_OFF, STATUS_OFF)
  - STATUS_EOC_BIT = 31
- One sub-module, boot_seq_prio_sel: combinational lowest-set-bit selector over (mask & ~done) with a start index. It is shared by the boot walk and the poll walk.

Test Plan:
- Mask 4'b0101, entry {0x1C008080 x4}, bootmode 3, gnt the same cycle as req -> six writes in order (t0 MODE/ENTRY/FETCH at 0x1A104000/4/8, then t2 at 0x1A104200/4/8), no target 1/3 accesses.
- After boot, t0 STATUS returns 0x8000_0000 and t2 returns 0x0 then 0x8000_0005 -> eoc_o=4'b0101, exit_status_o[2]=5, done_o pulses once, busy_o falls.
- gnt_i delayed 3 cycles and rvalid_i delayed 2 cycles -> req_o/addr_o/wdata_o stable throughout; no duplicate or skipped accesses.
- Mask 0 -> done_o one cycle after LATCH; no bus requests.
- rst_i asserted in RD_RSP, then a late rvalid_i -> outputs return to 0, the late response is ignored, and a new start_i runs cleanly.
- With BOOT_SEQ_CTRL_TIMEOUT_EN and TimeoutCycles=1000, STATUS never shows eoc -> error_o=1 and done_o by cycle 1000+bus latency; without the macro, busy_o stays 1.
